ram_dp_param: RTL and testbench

Parametrised simple dual-port synchronous RAM with one write port and one read port. It supersedes the fixed 16x8 RAM with generic width and depth, per-byte write enables, and selectable read latency. It adds a defined read-during-write policy, out-of-range address detection, and a hardware clear sequencer that zeroes every location after reset or on request. It sits as the general storage primitive under FIFOs and register banks.

---
 rtl/ram_pkg.sv | 28 ++
 rtl/ram_clear_ctrl.sv | 59 +++++
 rtl/ram_dp_param.sv | 151 +++++++++++++++
 tb/tb_ram_dp_param.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// Holds the clear-sweep state encoding and parameter legality rules.
package ram_pkg;

    typedef enum logic {
        READY,
        CLEAR
    } state_t;

    localparam int BYTE_BITS = 8;

    function automatic int be_width(input int dw);
        return dw / BYTE_BITS;
    endfunction

    function automatic bit params_ok(
        input int dw,
        input int depth,
        input int lat,
        input int wf
    );
        return (dw >= BYTE_BITS) && (dw % BYTE_BITS == 0) &&
               (depth >= 2) &&
               (lat == 1 || lat == 2) &&
               (wf == 0 || wf == 1);
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: sweeps every word to zero after reset or on request.
// Owns the write port while busy so user accesses are locked out.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [ADDR_WIDTH-1:0] clr_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // A clear request seen mid-sweep is dropped rather than restarting it.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        unique case (state)
            READY: begin
                if (clear) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == LAST) begin
                    state_nxt   = READY;
                    clr_ptr_nxt = '0;
                end
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/ram_dp_param.sv
// Simple dual-port RAM: byte-lane writes, 1 or 2 cycle reads,
// selectable collision policy, range checking and hardware clear.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_enb,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    addr_err,
    output logic                    busy
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    if (!params_ok(DATA_WIDTH, DEPTH, RD_LATENCY, WRITE_FIRST) ||
        ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_params
        $error("ram_dp_param: illegal parameter set");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clear_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;
    logic rd_ok;
    logic collide;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_ok       = wr_enb && !busy && wr_in_range;
    assign rd_ok       = rd_enb && !busy;
    assign collide     = (WRITE_FIRST != 0) && wr_ok && rd_in_range &&
                         (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][BYTE_BITS*k +: BYTE_BITS] <=
                        wr_data[BYTE_BITS*k +: BYTE_BITS];
                end
            end
        end
    end

    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] mem_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd_word;

    // Write-first bypass: forward the byte-merged word past the array.
    always_comb begin
        rd_idx   = rd_in_range ? rd_addr : '0;
        mem_word = mem[rd_idx];
        merged   = mem_word;
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (wr_be[k]) begin
                merged[BYTE_BITS*k +: BYTE_BITS] =
                    wr_data[BYTE_BITS*k +: BYTE_BITS];
            end
        end
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = collide ? merged : mem_word;
        end
    end

    logic                  s1_valid;
    logic                  s1_rerr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  werr;

    // A read error on the same cycle absorbs the write error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_rerr  <= 1'b0;
            s1_data  <= '0;
            werr     <= 1'b0;
        end else begin
            s1_valid <= rd_ok;
            s1_rerr  <= rd_ok && !rd_in_range;
            werr     <= wr_enb && !busy && !wr_in_range &&
                        !(rd_ok && !rd_in_range);
            if (rd_ok) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic                  s2_rerr;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (!rst) begin
                s2_valid <= 1'b0;
                s2_rerr  <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_rerr  <= s1_rerr;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
        assign addr_err = s2_rerr | werr;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
        assign addr_err = s1_rerr | werr;
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench: two RAM configurations share one stimulus stream and are
// compared every cycle against a behavioural model of the RAM.
module tb_ram_dp_param;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          wr_enb;
    logic [1:0]    wr_be;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_enb;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          addr_err_a, addr_err_b;
    logic          busy_a, busy_b;

    always #5 clk = ~clk;

    // A: non power-of-2 depth, 2-cycle read, write-first
    ram_dp_param #(
        .DATA_WIDTH  (16),
        .DEPTH       (12),
        .RD_LATENCY  (2),
        .WRITE_FIRST (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_enb   (wr_enb),
        .wr_be    (wr_be),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_enb   (rd_enb),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a),
        .addr_err (addr_err_a),
        .busy     (busy_a)
    );

    // B: power-of-2 depth, 1-cycle read, read-first
    ram_dp_param #(
        .DATA_WIDTH  (16),
        .DEPTH       (16),
        .RD_LATENCY  (1),
        .WRITE_FIRST (0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_enb   (wr_enb),
        .wr_be    (wr_be),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_enb   (rd_enb),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b),
        .addr_err (addr_err_b),
        .busy     (busy_b)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic int m_depth(input int d);
        return (d == 0) ? 12 : 16;
    endfunction
    function automatic int m_lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction
    function automatic bit m_wf(input int d);
        return (d == 0);
    endfunction

    // Model: word array, remaining sweep cycles, and a schedule of
    // output events indexed by the cycle at which they become visible.
    logic [DW-1:0] mm [2][16];
    int            sweep [2];
    bit            sv [2][4];
    bit            se [2][4];
    logic [DW-1:0] sd [2][4];
    bit            ev [2];
    bit            ee [2];
    logic [DW-1:0] ed [2];
    bit            model_live = 0;
    int            tcyc = 0;

    task automatic model_edge(input int d);
        int            s, slot, dep;
        bit            rd_oor, wr_oor;
        logic [DW-1:0] rv;
        s   = tcyc % 4;
        dep = m_depth(d);
        rv  = '0;
        if (!rst) begin
            for (int i = 0; i < 16; i++) mm[d][i] = '0;
            for (int i = 0; i < 4; i++) begin
                sv[d][i] = 0;
                se[d][i] = 0;
            end
            sweep[d] = dep;
            ev[d] = 0;
            ee[d] = 0;
            ed[d] = '0;
            return;
        end
        if (sweep[d] > 0) begin
            sweep[d]--;
        end else begin
            rd_oor = rd_enb && (int'(rd_addr) >= dep);
            wr_oor = wr_enb && (int'(wr_addr) >= dep);
            if (rd_enb && !m_wf(d)) rv = rd_oor ? '0 : mm[d][rd_addr];
            if (wr_enb && !wr_oor)
                for (int k = 0; k < 2; k++)
                    if (wr_be[k]) mm[d][wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            if (rd_enb && m_wf(d)) rv = rd_oor ? '0 : mm[d][rd_addr];
            if (rd_enb) begin
                slot = (tcyc + m_lat(d) - 1) % 4;
                sv[d][slot] = 1;
                sd[d][slot] = rv;
                se[d][slot] = rd_oor;
            end
            if (wr_oor && !rd_oor) se[d][s] = 1;
            if (clear) begin
                sweep[d] = dep;
                for (int i = 0; i < 16; i++) mm[d][i] = '0;
            end
        end
        ev[d] = sv[d][s];
        ee[d] = se[d][s];
        if (sv[d][s]) ed[d] = sd[d][s];
        sv[d][s] = 0;
        se[d][s] = 0;
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_edge(d);
        if (!rst) model_live = 1;
        tcyc++;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("a_busy", {15'b0, busy_a}, {15'b0, sweep[0] > 0});
            chk("a_valid", {15'b0, rd_valid_a}, {15'b0, ev[0]});
            chk("a_err", {15'b0, addr_err_a}, {15'b0, ee[0]});
            chk("a_data", rd_data_a, ed[0]);
            chk("b_busy", {15'b0, busy_b}, {15'b0, sweep[1] > 0});
            chk("b_valid", {15'b0, rd_valid_b}, {15'b0, ev[1]});
            chk("b_err", {15'b0, addr_err_b}, {15'b0, ee[1]});
            chk("b_data", rd_data_b, ed[1]);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic idle();
        wr_enb = 0;
        rd_enb = 0;
        clear  = 0;
    endtask
    task automatic wr(input int a, input logic [DW-1:0] d, input logic [1:0] be);
        wr_enb  = 1;
        wr_addr = AW'(a);
        wr_data = d;
        wr_be   = be;
    endtask
    task automatic rd(input int a);
        rd_enb  = 1;
        rd_addr = AW'(a);
    endtask

    int na, nb, nz;

    initial begin
        rst = 0; clear = 0; wr_enb = 0; rd_enb = 0;
        wr_be = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        cyc(2);
        chk("rst_valid_b", {15'b0, rd_valid_b}, 16'd0);
        chk("rst_data_a", rd_data_a, 16'd0);
        chk("rst_busy_b", {15'b0, busy_b}, 16'd1);
        rst = 1;

        na = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            cyc();
        end
        chk("sweep_len_a", 16'(na), 16'd12);
        chk("sweep_len_b", 16'(nb), 16'd16);

        nb = 0; nz = 0;
        for (int i = 0; i < 16; i++) begin
            rd(i);
            cyc();
            if (rd_valid_b) begin
                nb++;
                if (rd_data_b != 0) nz++;
            end
        end
        idle();
        cyc(2);
        chk("zero_reads_b", 16'(nb), 16'd16);
        chk("zero_data_b", 16'(nz), 16'd0);

        wr(3, 16'hABCD, 2'b11); cyc();
        wr(3, 16'h1234, 2'b01); cyc();
        idle(); rd(3); cyc(); idle();
        chk("be_merge_b", rd_data_b, 16'hAB34);
        cyc();
        chk("be_merge_a", rd_data_a, 16'hAB34);
        chk("be_valid_a", {15'b0, rd_valid_a}, 16'd1);

        wr(7, 16'h0011, 2'b11); cyc();
        wr(7, 16'h005A, 2'b11); rd(7); cyc(); idle();
        chk("coll_old_b", rd_data_b, 16'h0011);
        cyc();
        chk("coll_new_a", rd_data_a, 16'h005A);
        rd(7); cyc(); idle();
        chk("coll_next_b", rd_data_b, 16'h005A);
        cyc(2);

        for (int i = 0; i < 16; i++) begin
            wr(i, 16'(i * 3), 2'b11);
            cyc();
        end
        idle();
        cyc(2);
        for (int i = 0; i < 16; i++) begin
            rd(i);
            cyc();
            chk("stream_b", rd_data_b, 16'(i * 3));
            if (i == 0) chk("stream_a_first", {15'b0, rd_valid_a}, 16'd0);
            else chk("stream_a", rd_data_a, (i - 1 < 12) ? 16'((i - 1) * 3) : 16'h0);
        end
        idle();
        cyc();
        chk("stream_a_last", rd_data_a, 16'h0);
        chk("stream_a_err", {15'b0, addr_err_a}, 16'd1);
        cyc();
        rd(5); cyc(); idle(); cyc();
        chk("hold_a_valid", {15'b0, rd_valid_a}, 16'd1);
        chk("hold_a_data", rd_data_a, 16'd15);
        cyc();
        chk("hold_a_drop", {15'b0, rd_valid_a}, 16'd0);
        chk("hold_a_keep", rd_data_a, 16'd15);

        wr(13, 16'hFFFF, 2'b11); cyc(); idle();
        chk("werr_a", {15'b0, addr_err_a}, 16'd1);
        cyc();
        chk("werr_a_once", {15'b0, addr_err_a}, 16'd0);
        rd(14); cyc(); idle(); cyc();
        chk("rerr_a_data", rd_data_a, 16'h0);
        chk("rerr_a_valid", {15'b0, rd_valid_a}, 16'd1);
        chk("rerr_a_err", {15'b0, addr_err_a}, 16'd1);
        rd(1); cyc(); idle(); cyc();
        chk("no_alias_a", rd_data_a, 16'd3);

        clear = 1; cyc(); clear = 0;
        chk("clr_busy_b", {15'b0, busy_b}, 16'd1);
        cyc(4);
        rst = 0; cyc(); rst = 1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_b) begin
                nb++;
                wr(2, 16'hBEEF, 2'b11);
            end else begin
                idle();
            end
            cyc();
        end
        idle();
        chk("restart_len_b", 16'(nb), 16'd16);
        rd(2); cyc(); idle();
        chk("lost_wr_b", rd_data_b, 16'h0);
        cyc();

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) != 0);
            clear   = ($urandom_range(0, 79) == 0);
            wr_enb  = 1'($urandom_range(0, 1));
            rd_enb  = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            wr_be   = 2'($urandom_range(0, 3));
            cyc();
        end
        rst = 1;
        idle();
        cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
